// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU definitions for the memory/write-back stage: load type codes,
// stage FSM encoding and the hard-wired zero register.
package mem_wb_stage_pkg;

  localparam logic [2:0] LOAD_LW  = 3'd0;
  localparam logic [2:0] LOAD_LH  = 3'd1;
  localparam logic [2:0] LOAD_LHU = 3'd2;
  localparam logic [2:0] LOAD_LB  = 3'd3;
  localparam logic [2:0] LOAD_LBU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/load_extend.sv
// Little-endian load alignment: selects the byte/half addressed by offset
// and sign- or zero-extends it; unknown type codes behave as a full word.
module load_extend
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        load_type,
  input  logic [1:0]        offset,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    // Halfword alignment only looks at offset[1]; offset[0] is ignored.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (load_type)
      LOAD_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
      LOAD_LH:  data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LOAD_LHU: data = {{(DATA_W-16){1'b0}}, half_sel};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: captures retiring instructions, waits for load
// data, extends it and drives the register-file write port plus forwarding.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_is_load,
  input  logic [2:0]        in_load_type,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_rvalid,
  input  logic              flush,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              load_pending,
  output logic [ADDR_W-1:0] load_pending_addr,
  output logic [1:0]        state_dbg
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  wb_state_e state_q, state_d;
  logic      accept;
  logic      load_done;

  logic [ADDR_W-1:0] waddr_q;
  logic              wen_q;
  logic [2:0]        type_q;
  logic [1:0]        offset_q;
  logic [DATA_W-1:0] ext_data;

  logic              rf_wen_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .rdata     (dmem_rdata),
    .load_type (type_q),
    .offset    (offset_q),
    .data      (ext_data)
  );

  // Handshake: an instruction transfers when in_valid & in_ready & ~flush on
  // a rising edge; in_ready drops only while a load waits for dmem_rvalid.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b1;
    accept    = 1'b0;
    load_done = 1'b0;
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        accept  = in_valid & ~flush;
        state_d = accept ? (in_is_load ? ST_WAIT_MEM : ST_WRITE) : ST_IDLE;
      end
      ST_WAIT_MEM: begin
        in_ready = 1'b0;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (dmem_rvalid) begin
          load_done = 1'b1;
          state_d   = ST_WRITE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      waddr_q    <= '0;
      wen_q      <= 1'b0;
      type_q     <= LOAD_LW;
      offset_q   <= 2'd0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      rf_wen_q <= 1'b0;
      if (accept) begin
        waddr_q  <= in_waddr;
        wen_q    <= in_wen;
        type_q   <= in_load_type;
        offset_q <= in_result[1:0];
        // ALU results skip WAIT_MEM and are presented on the very next cycle.
        if (!in_is_load) begin
          rf_wen_q   <= in_wen & (in_waddr != ZERO_ADDR);
          rf_waddr_q <= in_waddr;
          rf_wdata_q <= in_result;
        end
      end
      if (load_done) begin
        rf_wen_q   <= wen_q & (waddr_q != ZERO_ADDR);
        rf_waddr_q <= waddr_q;
        rf_wdata_q <= ext_data;
      end
    end
  end

  assign rf_wen            = rf_wen_q;
  assign rf_waddr          = rf_waddr_q;
  assign rf_wdata          = rf_wdata_q;
  assign fwd_valid         = rf_wen_q;
  assign fwd_addr          = rf_waddr_q;
  assign fwd_data          = rf_wdata_q;
  assign load_pending      = (state_q == ST_WAIT_MEM) & wen_q & (waddr_q != ZERO_ADDR);
  assign load_pending_addr = waddr_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level model with an expected-write queue.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::ST_IDLE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_wen, in_is_load;
  logic [4:0]  in_waddr;
  logic [31:0] in_result, dmem_rdata;
  logic [2:0]  in_load_type;
  logic        dmem_rvalid, flush;
  logic        rf_wen, fwd_valid, load_pending;
  logic [4:0]  rf_waddr, fwd_addr, load_pending_addr;
  logic [31:0] rf_wdata, fwd_data;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: is a load outstanding, and is a write expected this cycle.
  logic        m_wait = 1'b0;
  logic        m_wr   = 1'b0;
  logic        m_ld_wen;
  logic [4:0]  m_ld_addr;
  logic [2:0]  m_ld_type;
  logic [1:0]  m_ld_off;
  logic [36:0] exp_q[$];

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
    .in_waddr(in_waddr), .in_result(in_result), .in_is_load(in_is_load),
    .in_load_type(in_load_type), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
    .flush(flush), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .load_pending(load_pending), .load_pending_addr(load_pending_addr),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_extend(input logic [31:0] d, input logic [2:0] t,
                                             input logic [1:0] off);
    int v;
    case (t)
      3'd3, 3'd4: begin
        v = int'((d >> (8 * off)) & 32'hFF);
        if (t == 3'd3 && v >= 128) v -= 256;
      end
      3'd1, 3'd2: begin
        v = int'((d >> (16 * (off / 2))) & 32'hFFFF);
        if (t == 3'd1 && v >= 32768) v -= 65536;
      end
      default: v = int'(d);
    endcase
    return 32'(v);
  endfunction

  task automatic model_step();
    logic        w = 1'b0;
    logic [4:0]  a = '0;
    logic [31:0] d = '0;
    if (!rst_n) begin
      m_wait = 1'b0;
      exp_q.delete();
    end else if (m_wait) begin
      if (flush) begin
        m_wait = 1'b0;
      end else if (dmem_rvalid) begin
        m_wait = 1'b0;
        w = m_ld_wen && (m_ld_addr != 0);
        a = m_ld_addr;
        d = ref_extend(dmem_rdata, m_ld_type, m_ld_off);
      end
    end else if (in_valid && !flush) begin
      if (in_is_load) begin
        m_wait    = 1'b1;
        m_ld_wen  = in_wen;
        m_ld_addr = in_waddr;
        m_ld_type = in_load_type;
        m_ld_off  = in_result[1:0];
      end else begin
        w = in_wen && (in_waddr != 0);
        a = in_waddr;
        d = in_result;
      end
    end
    m_wr = w;
    if (w) exp_q.push_back({a, d});
  endtask

  task automatic check_outputs();
    logic [36:0] e;
    check("rf_wen", 32'(rf_wen), 32'(m_wr));
    check("fwd_valid", 32'(fwd_valid), 32'(m_wr));
    check("in_ready", 32'(in_ready), 32'(!m_wait));
    check("load_pending", 32'(load_pending), 32'(m_wait && m_ld_wen && m_ld_addr != 0));
    if (m_wait && m_ld_wen && m_ld_addr != 0)
      check("load_pending_addr", 32'(load_pending_addr), 32'(m_ld_addr));
    if (rf_wen && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rf_waddr", 32'(rf_waddr), 32'(e[36:32]));
      check("rf_wdata", rf_wdata, e[31:0]);
      check("fwd_addr", 32'(fwd_addr), 32'(e[36:32]));
      check("fwd_data", fwd_data, e[31:0]);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; in_valid = 1'b0; in_wen = 1'b0; in_waddr = '0; in_result = '0;
    in_is_load = 1'b0; in_load_type = '0; dmem_rdata = '0; dmem_rvalid = 1'b0; flush = 1'b0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] res);
    in_valid = 1'b1; in_wen = 1'b1; in_waddr = a; in_result = res; in_is_load = 1'b0;
  endtask

  // Load accepted at cycle 0, dmem_rvalid presented at cycle 3.
  task automatic do_load(input logic [4:0] a, input logic [31:0] res, input logic [2:0] t,
                         input logic [31:0] rd, input logic [31:0] exp, input logic exp_wr);
    idle_inputs();
    alu(a, res);
    in_is_load = 1'b1; in_load_type = t;
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check("ld_wait_ready", 32'(in_ready), 32'd0);
      check("ld_pending", 32'(load_pending), 32'(exp_wr));
      if (exp_wr) check("ld_pending_addr", 32'(load_pending_addr), 32'(a));
      if (i < 2) begin
        dmem_rdata = $urandom;
        step();
      end
    end
    dmem_rdata = rd; dmem_rvalid = 1'b1;
    step();
    check("ld_wen", 32'(rf_wen), 32'(exp_wr));
    if (exp_wr) check("ld_data", rf_wdata, exp);
    check("ld_ready_after", 32'(in_ready), 32'd1);
    idle_inputs();
    step();
    check("ld_pulse", 32'(rf_wen), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_pending_addr", 32'(load_pending_addr), 32'd0);

    idle_inputs();
    alu(5'd3, 32'h0000_1234);
    step();
    check("add_wen", 32'(rf_wen), 32'd1);
    check("add_addr", 32'(rf_waddr), 32'd3);
    check("add_data", rf_wdata, 32'h0000_1234);
    check("add_fwd", 32'(fwd_valid), 32'd1);
    idle_inputs();
    step();
    check("add_pulse", 32'(rf_wen), 32'd0);

    do_load(5'd5, 32'h1000_0002, 3'd3, 32'h0080_0000, 32'hFFFF_FF80, 1'b1);
    do_load(5'd5, 32'h1000_0002, 3'd4, 32'h0080_0000, 32'h0000_0080, 1'b1);
    do_load(5'd7, 32'h1000_0002, 3'd1, 32'h8001_7FFF, 32'hFFFF_8001, 1'b1);
    do_load(5'd7, 32'h1000_0003, 3'd1, 32'h8001_7FFF, 32'hFFFF_8001, 1'b1);
    do_load(5'd7, 32'h1000_0002, 3'd2, 32'h8001_7FFF, 32'h0000_8001, 1'b1);
    do_load(5'd8, 32'h1000_0002, 3'd0, 32'h8001_7FFF, 32'h8001_7FFF, 1'b1);
    do_load(5'd8, 32'h1000_0001, 3'd6, 32'h8001_7FFF, 32'h8001_7FFF, 1'b1);
    do_load(5'd0, 32'h1000_0000, 3'd0, 32'h1234_5678, 32'h0, 1'b0);

    idle_inputs();
    alu(5'd0, 32'hDEAD_BEEF);
    step();
    check("r0_wen", 32'(rf_wen), 32'd0);
    check("r0_fwd", 32'(fwd_valid), 32'd0);

    for (int i = 1; i <= 4; i++) begin
      alu(5'(i), 32'h1111 * i);
      step();
      check("b2b_wen", 32'(rf_wen), 32'd1);
      check("b2b_ready", 32'(in_ready), 32'd1);
      check("b2b_addr", 32'(rf_waddr), 32'(i));
      check("b2b_data", rf_wdata, 32'h1111 * i);
    end
    idle_inputs();
    step();

    idle_inputs();
    alu(5'd9, 32'h0);
    in_is_load = 1'b1;
    step();
    idle_inputs();
    flush = 1'b1;
    step();
    check("flush_ready", 32'(in_ready), 32'd1);
    check("flush_pending", 32'(load_pending), 32'd0);
    idle_inputs();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    step();
    check("flush_late_rvalid", 32'(rf_wen), 32'd0);

    idle_inputs();
    alu(5'd10, 32'hA0A0_A0A0);
    step();
    alu(5'd11, 32'hB1B1_B1B1);
    flush = 1'b1;
    step();
    check("flush_beats_accept", 32'(rf_wen), 32'd0);

    idle_inputs();
    alu(5'd12, 32'h0C0C_0C0C);
    step();
    check("pre_rst_wen", 32'(rf_wen), 32'd1);
    alu(5'd13, 32'h0D0D_0D0D);
    rst_n = 1'b0;
    step();
    check("rst_in_write_wen", 32'(rf_wen), 32'd0);
    check("rst_in_write_state", 32'(state_dbg), 32'(ST_IDLE));

    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      in_valid     = ($urandom_range(0, 9) < 7);
      in_wen       = ($urandom_range(0, 7) != 0);
      in_waddr     = 5'($urandom_range(0, 31));
      in_result    = $urandom;
      in_is_load   = ($urandom_range(0, 1) == 1);
      in_load_type = 3'($urandom_range(0, 7));
      dmem_rdata   = $urandom;
      dmem_rvalid  = ($urandom_range(0, 9) < 4);
      flush        = ($urandom_range(0, 19) == 0);
      step();
    end

    idle_inputs();
    rst_n = 1'b0;
    step();
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
